// File: rtl/matmul_pkg.sv
// matmul_pkg: shared sizes and FSM state encoding for the matrix-multiply engine
package matmul_pkg;
  localparam int DATA_W      = 16;
  localparam int MAX_DIM     = 4;
  localparam int BUS_W       = DATA_W * MAX_DIM;
  localparam int SP_NTARGETS = 4;
  localparam int RES_W       = 2 * DATA_W;
  localparam int DIM_W       = $clog2(MAX_DIM);
  localparam int TGT_W       = $clog2(SP_NTARGETS);
  typedef enum logic [2:0] {IDLE, LOAD_B, FETCH_A, WAIT_A, MAC, WRITE, DONE} state_t;
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one signed multiply-accumulate lane, wrapping modulo 2^RES_W
module mac_lane
  import matmul_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic        [RES_W-1:0]  acc_o
);
  logic        [RES_W-1:0] r_acc;
  logic signed [RES_W-1:0] w_prod;
  assign w_prod = a_i * b_i;
  assign acc_o  = r_acc;
  // accumulator: cleared per result row, adds one full-width product per enabled cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_acc <= '0;
    else if (clear_i) r_acc <= '0;
    else if (en_i) r_acc <= r_acc + w_prod;
  end
endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: loads B, then streams A rows through MAX_DIM MAC lanes and writes C rows
module matmul_engine
  import matmul_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [DIM_W-1:0]           dim_n_i,
  input  logic [DIM_W-1:0]           dim_k_i,
  input  logic [DIM_W-1:0]           dim_m_i,
  input  logic [TGT_W-1:0]           sp_target_i,
  output logic                       op_rd_en_o,
  output logic                       op_rd_sel_o,
  output logic [DIM_W-1:0]           op_rd_addr_o,
  input  logic [BUS_W-1:0]           op_rd_data_i,
  output logic                       sp_we_o,
  output logic [TGT_W-1:0]           sp_target_o,
  output logic [DIM_W-1:0]           sp_addr_o,
  output logic [MAX_DIM*RES_W-1:0]   sp_wdata_o,
  output logic                       busy_o,
  output logic                       done_o
);
  state_t             r_state, w_next;
  logic [DIM_W-1:0]   r_n, r_kd, r_m, r_i, r_k;
  logic [TGT_W-1:0]   r_tgt;
  logic               r_phase;
  logic [BUS_W-1:0]   r_a;
  logic [DATA_W-1:0]  r_b [MAX_DIM][MAX_DIM];
  logic [RES_W-1:0]   w_acc [MAX_DIM];
  logic [DATA_W-1:0]  w_a;
  logic               w_last_k, w_last_i, w_load_issue;
  assign w_last_k     = r_k == r_kd;
  assign w_last_i     = r_i == r_n;
  assign w_load_issue = (r_state == LOAD_B) && !r_phase;
  assign w_a          = r_a[r_k*DATA_W +: DATA_W];
  // state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state and strobed outputs; every output is zero unless its strobe is high
  always_comb begin
    w_next       = r_state;
    op_rd_en_o   = w_load_issue || (r_state == FETCH_A);
    op_rd_sel_o  = w_load_issue;
    op_rd_addr_o = w_load_issue ? r_k : (r_state == FETCH_A) ? r_i : '0;
    sp_we_o      = r_state == WRITE;
    sp_target_o  = sp_we_o ? r_tgt : '0;
    sp_addr_o    = sp_we_o ? r_i : '0;
    sp_wdata_o   = '0;
    busy_o       = r_state != IDLE;
    done_o       = r_state == DONE;
    for (int j = 0; j < MAX_DIM; j++) if (sp_we_o) sp_wdata_o[j*RES_W +: RES_W] = w_acc[j];
    case (r_state)
      IDLE:    w_next = start_i ? LOAD_B : IDLE;
      LOAD_B:  w_next = (r_phase && w_last_k) ? FETCH_A : LOAD_B;
      FETCH_A: w_next = WAIT_A;
      WAIT_A:  w_next = MAC;
      MAC:     w_next = w_last_k ? WRITE : MAC;
      WRITE:   w_next = w_last_i ? DONE : FETCH_A;
      default: w_next = IDLE;
    endcase
  end
  // datapath: latch job on start, capture operand rows, step row/column counters
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      {r_n, r_kd, r_m, r_i, r_k, r_tgt, r_phase, r_a} <= '0;
      for (int k = 0; k < MAX_DIM; k++) for (int j = 0; j < MAX_DIM; j++) r_b[k][j] <= '0;
    end else if (r_state == IDLE) begin
      if (start_i) {r_n, r_kd, r_m, r_tgt} <= {dim_n_i, dim_k_i, dim_m_i, sp_target_i};
      {r_i, r_k, r_phase} <= '0;
    end else if (r_state == LOAD_B) begin
      r_phase <= ~r_phase;
      if (r_phase) begin
        for (int j = 0; j < MAX_DIM; j++) r_b[r_k][j] <= op_rd_data_i[j*DATA_W +: DATA_W];
        r_k <= w_last_k ? '0 : r_k + 1'b1;
      end
    end else if (r_state == WAIT_A) r_a <= op_rd_data_i;
    else if (r_state == MAC) r_k <= w_last_k ? '0 : r_k + 1'b1;
    else if (r_state == WRITE) r_i <= r_i + 1'b1;
  end
  for (genvar j = 0; j < MAX_DIM; j++) begin : g_lane
    mac_lane u_lane (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (r_state == FETCH_A),
      .en_i    ((r_state == MAC) && (DIM_W'(j) <= r_m)),
      .a_i     (w_a),
      .b_i     (r_b[r_k][j]),
      .acc_o   (w_acc[j])
    );
  end
endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: scoreboard bench comparing written C rows against a plain matrix product
module tb_matmul_engine;
  import matmul_pkg::*;
  logic                     clk = 0, reset_i = 0, start_i = 0;
  logic [DIM_W-1:0]         dim_n_i = 0, dim_k_i = 0, dim_m_i = 0;
  logic [TGT_W-1:0]         sp_target_i = 0;
  logic                     op_rd_en_o, op_rd_sel_o, sp_we_o, busy_o, done_o;
  logic [DIM_W-1:0]         op_rd_addr_o, sp_addr_o;
  logic [BUS_W-1:0]         op_rd_data_i = '0, pend = '0;
  logic [TGT_W-1:0]         sp_target_o;
  logic [MAX_DIM*RES_W-1:0] sp_wdata_o;
  logic [15:0]              ma [4][4], mb [4][4];
  int                       tests = 0, fails = 0;
  typedef struct {logic [1:0] addr; logic [127:0] data; logic [1:0] tgt;} exp_t;
  exp_t q[$];

  matmul_engine dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .dim_n_i(dim_n_i), .dim_k_i(dim_k_i), .dim_m_i(dim_m_i), .sp_target_i(sp_target_i),
    .op_rd_en_o(op_rd_en_o), .op_rd_sel_o(op_rd_sel_o), .op_rd_addr_o(op_rd_addr_o),
    .op_rd_data_i(op_rd_data_i), .sp_we_o(sp_we_o), .sp_target_o(sp_target_o),
    .sp_addr_o(sp_addr_o), .sp_wdata_o(sp_wdata_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // operand bank model: request seen mid-cycle, row presented for the following cycle
  always @(negedge clk) begin
    pend = '0;
    if (op_rd_en_o) for (int j = 0; j < 4; j++)
      pend[j*16 +: 16] = op_rd_sel_o ? mb[op_rd_addr_o][j] : ma[op_rd_addr_o][j];
  end
  always @(posedge clk) op_rd_data_i <= pend;

  // monitor: pops the scoreboard on every result write, checks idle outputs otherwise
  always @(negedge clk) begin
    if (sp_we_o) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", sp_addr_o, sp_wdata_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 128'(sp_addr_o), 128'(e.addr));
        chk("wr_data", sp_wdata_o, e.data);
        chk("wr_target", 128'(sp_target_o), 128'(e.tgt));
      end
    end else chk("sp_idle_zero", {sp_target_o, sp_addr_o, sp_wdata_o}, '0);
    if (!op_rd_en_o) chk("op_idle_zero", 128'({op_rd_sel_o, op_rd_addr_o}), '0);
  end

  task automatic fill_rand();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      ma[i][j] = 16'($urandom);
      mb[i][j] = 16'($urandom);
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      ma[i][j] = (i == j) ? 16'd1 : 16'd0;
      mb[i][j] = 16'(i * 4 + j + 1);
    end
  endtask

  // mode 0: plain run, 1: re-start and input changes mid-job, 2: reset during WRITE of row 1
  task automatic run(int n, int k, int m, int tgt, int mode);
    logic [127:0] row;
    longint s;
    int c, dc;
    for (int i = 0; i < n; i++) begin
      row = '0;
      for (int j = 0; j < m; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'($signed(ma[i][kk])) * longint'($signed(mb[kk][j]));
        row[j*32 +: 32] = s[31:0];
      end
      q.push_back('{addr: 2'(i), data: row, tgt: 2'(tgt)});
    end
    @(negedge clk);
    start_i = 1; dim_n_i = 2'(n - 1); dim_k_i = 2'(k - 1); dim_m_i = 2'(m - 1); sp_target_i = 2'(tgt);
    @(negedge clk);
    start_i = 0;
    if (mode == 1) begin dim_n_i = 0; dim_k_i = 0; dim_m_i = 0; sp_target_i = 2'(tgt ^ 1); end
    dc = 2 * k + n * (k + 3) + 1;
    for (c = 1; c <= dc; c++) begin
      chk("busy_active", 128'(busy_o), 128'(1));
      chk("done_timing", 128'(done_o), 128'(c == dc));
      if (mode == 2 && c == 2 * k + 2 * (k + 3)) begin
        #2 reset_i = 1;
        #1 chk("reset_outputs", {busy_o, done_o, op_rd_en_o, op_rd_sel_o, op_rd_addr_o, sp_we_o, sp_target_o, sp_addr_o, sp_wdata_o}, '0);
        q.delete();
        @(negedge clk);
        reset_i = 0;
        return;
      end
      start_i = (mode == 1) && (c == 2 * k + 3);
      @(negedge clk);
    end
    start_i = 0;
    chk("busy_after_done", 128'(busy_o), '0);
    chk("done_after_done", 128'(done_o), '0);
    chk("writes_all_seen", 128'(q.size()), '0);
    dim_n_i = 0; dim_k_i = 0; dim_m_i = 0; sp_target_i = 0;
  endtask

  initial begin
    fill_identity();
    #1 reset_i = 1;
    #2 chk("reset_state", {busy_o, done_o, op_rd_en_o, sp_we_o, sp_wdata_o}, '0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 0;
    run(4, 4, 4, 2, 0);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
    ma[0][0] = 1; ma[0][1] = 2; ma[0][2] = 3; ma[1][0] = 4; ma[1][1] = 5; ma[1][2] = 6;
    mb[0][0] = 7; mb[0][1] = 8; mb[1][0] = 9; mb[1][1] = 10; mb[2][0] = 11; mb[2][1] = 12;
    run(2, 3, 2, 0, 0);
    fill_rand();
    ma[0][0] = 16'hFFFF; mb[0][0] = 16'h7FFF;
    run(1, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ma[i][j] = 16'h8000; mb[i][j] = 16'h8000; end
    run(1, 4, 1, 3, 0);
    fill_identity();
    run(4, 4, 4, 2, 1);
    run(4, 4, 4, 2, 2);
    run(4, 4, 4, 2, 0);
    repeat (20) begin
      fill_rand();
      run(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
